// File: rtl/nv_lane_sched_if.sv
// Lane scheduler bus: game-side controls in, lane load/shift strobes out.
// The game FSM side uses the master modport; the scheduler uses slave.
interface nv_lane_sched_if #(
  parameter int unsigned DATAWIDTH_BUS    = 8,
  parameter int unsigned DATAWIDTH_ESTADO = 3,
  parameter int unsigned DATAWIDTH_NVL    = 2
);
  logic [DATAWIDTH_ESTADO-1:0] SC_LANESCHED_ESTADO_IN;
  logic [DATAWIDTH_NVL-1:0]    SC_LANESCHED_NVL_IN;
  logic                        SC_LANESCHED_CN_IN;
  logic                        SC_LANESCHED_TICK_IN;
  logic [DATAWIDTH_BUS-1:0]    SC_LANESCHED_PAT_OUT;
  logic [3:0]                  SC_LANESCHED_LOAD_OUT;
  logic [3:0]                  SC_LANESCHED_SHIFT_OUT;
  logic                        SC_LANESCHED_BUSY_OUT;

  modport master (
    output SC_LANESCHED_ESTADO_IN, SC_LANESCHED_NVL_IN, SC_LANESCHED_CN_IN, SC_LANESCHED_TICK_IN,
    input  SC_LANESCHED_PAT_OUT, SC_LANESCHED_LOAD_OUT, SC_LANESCHED_SHIFT_OUT,
           SC_LANESCHED_BUSY_OUT
  );

  modport slave (
    input  SC_LANESCHED_ESTADO_IN, SC_LANESCHED_NVL_IN, SC_LANESCHED_CN_IN, SC_LANESCHED_TICK_IN,
    output SC_LANESCHED_PAT_OUT, SC_LANESCHED_LOAD_OUT, SC_LANESCHED_SHIFT_OUT,
           SC_LANESCHED_BUSY_OUT
  );
endinterface

// File: rtl/nv_lane_sched.sv
// Four-lane traffic level scheduler: loads each lane's pattern over the shared
// bus, then issues per-lane shift strobes at level-scaled periods of the base tick.
// Optional macro LANESCHED_STAGGER_EN: due lanes queue in a pending register and
// are released one per cycle, lowest index first, so SHIFT_OUT is never multi-hot.
module nv_lane_sched #(
  parameter int unsigned               DATAWIDTH_BUS    = 8,
  parameter int unsigned               DATAWIDTH_ESTADO = 3,
  parameter int unsigned               DATAWIDTH_NVL    = 2,
  parameter int unsigned               PERW             = 4,
  parameter logic [DATAWIDTH_BUS-1:0] LANE0_PAT        = 8'hC0,
  parameter logic [DATAWIDTH_BUS-1:0] LANE1_PAT        = 8'h30,
  parameter logic [DATAWIDTH_BUS-1:0] LANE2_PAT        = 8'h0C,
  parameter logic [DATAWIDTH_BUS-1:0] LANE3_PAT        = 8'h81,
  parameter int unsigned               LANE0_PER        = 8,
  parameter int unsigned               LANE1_PER        = 6,
  parameter int unsigned               LANE2_PER        = 4,
  parameter int unsigned               LANE3_PER        = 12
) (
  input logic            SC_LANESCHED_CLOCK_50,
  input logic            SC_LANESCHED_RESET,
  nv_lane_sched_if.slave bus
);

  localparam logic [DATAWIDTH_ESTADO-1:0] EstPlay  = DATAWIDTH_ESTADO'(1);
  localparam logic [DATAWIDTH_ESTADO-1:0] EstPause = DATAWIDTH_ESTADO'(2);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StPause} state_e;

  state_e                     state_q, state_d;
  logic [1:0]                 idx_q, idx_d;
  logic [DATAWIDTH_NVL-1:0]   lvl_q, lvl_d;
  logic [PERW-1:0]            cnt_q [4];
  logic [PERW-1:0]            cnt_d [4];
  logic [DATAWIDTH_BUS-1:0]   pat_q, pat_d;
  logic [3:0]                 load_q, load_d;
  logic [3:0]                 shift_q, shift_d;
  logic                       busy_q, busy_d;
  logic [3:0]                 due;
  logic                       stay_run;
  logic                       is_play, is_pause, is_stop;

`ifdef LANESCHED_STAGGER_EN
  logic [3:0] pend_q, pend_d;
  logic [3:0] req, grant;
`endif

  function automatic logic [DATAWIDTH_BUS-1:0] lane_pat(input logic [1:0] k);
    logic [DATAWIDTH_BUS-1:0] p;
    unique case (k)
      2'd0: p = LANE0_PAT;
      2'd1: p = LANE1_PAT;
      2'd2: p = LANE2_PAT;
      2'd3: p = LANE3_PAT;
    endcase
    return p;
  endfunction

  // Effective period: base period shifted down by level, never below 1.
  function automatic logic [PERW-1:0] eff_per(input logic [1:0] k,
                                               input logic [DATAWIDTH_NVL-1:0] l);
    logic [PERW-1:0] base;
    logic [PERW-1:0] p;
    unique case (k)
      2'd0: base = PERW'(LANE0_PER);
      2'd1: base = PERW'(LANE1_PER);
      2'd2: base = PERW'(LANE2_PER);
      2'd3: base = PERW'(LANE3_PER);
    endcase
    p = base >> l;
    if (p == '0) p = PERW'(1);
    return p;
  endfunction

  // Rotate left by the latched level, via the upper half of a doubled word.
  function automatic logic [DATAWIDTH_BUS-1:0] rotl(input logic [DATAWIDTH_BUS-1:0] p,
                                                    input logic [DATAWIDTH_NVL-1:0] l);
    logic [2*DATAWIDTH_BUS-1:0] w;
    w = {p, p} << l;
    return w[2*DATAWIDTH_BUS-1:DATAWIDTH_BUS];
  endfunction

  assign is_play  = (bus.SC_LANESCHED_ESTADO_IN == EstPlay);
  assign is_pause = (bus.SC_LANESCHED_ESTADO_IN == EstPause);
  assign is_stop  = !is_play && !is_pause;

  // Next-state, lane counters and registered-output values.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lvl_d    = lvl_q;
    cnt_d    = cnt_q;
    due      = '0;
    stay_run = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (is_play) begin
          state_d = StLoad;
          lvl_d   = bus.SC_LANESCHED_NVL_IN;
          idx_d   = 2'd0;
        end
      end
      StLoad: begin
        if (idx_q == 2'd3) begin
          state_d = StRun;
          for (int k = 0; k < 4; k++) cnt_d[k] = '0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      StRun: begin
        if (is_stop) begin
          state_d = StIdle;
        end else if (bus.SC_LANESCHED_CN_IN) begin
          state_d = StLoad;
          lvl_d   = bus.SC_LANESCHED_NVL_IN;
          idx_d   = 2'd0;
        end else if (is_pause) begin
          state_d = StPause;
        end else begin
          stay_run = 1'b1;
        end
      end
      StPause: begin
        if (is_stop) begin
          state_d = StIdle;
        end else if (bus.SC_LANESCHED_CN_IN) begin
          state_d = StLoad;
          lvl_d   = bus.SC_LANESCHED_NVL_IN;
          idx_d   = 2'd0;
        end else if (is_play) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase

    // Ticks only count while RUN persists; a tick on a leaving cycle is dropped.
    if (stay_run && bus.SC_LANESCHED_TICK_IN) begin
      for (int k = 0; k < 4; k++) begin
        if (cnt_q[k] == eff_per(2'(k), lvl_q) - PERW'(1)) begin
          cnt_d[k] = '0;
          due[k]   = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + PERW'(1);
        end
      end
    end

    busy_d = (state_d == StLoad);
    load_d = (state_d == StLoad) ? (4'b0001 << idx_d) : 4'b0000;
    pat_d  = (state_d == StLoad) ? rotl(lane_pat(idx_d), lvl_d) : '0;

`ifdef LANESCHED_STAGGER_EN
    req     = pend_q | due;
    grant   = req & (~req + 4'd1);
    pend_d  = pend_q;
    shift_d = 4'b0000;
    if (state_d == StLoad || state_d == StIdle) begin
      pend_d = '0;
    end else if (stay_run) begin
      shift_d = grant;
      pend_d  = req & ~grant;
    end
`else
    shift_d = due;
`endif
  end

  // State, counters and registered outputs.
  always_ff @(posedge SC_LANESCHED_CLOCK_50 or negedge SC_LANESCHED_RESET) begin
    if (!SC_LANESCHED_RESET) begin
      state_q <= StIdle;
      idx_q   <= '0;
      lvl_q   <= '0;
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
      pat_q   <= '0;
      load_q  <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      load_q  <= load_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
    end
  end

`ifdef LANESCHED_STAGGER_EN
  // Pending due lanes waiting for their one-hot shift slot.
  always_ff @(posedge SC_LANESCHED_CLOCK_50 or negedge SC_LANESCHED_RESET) begin
    if (!SC_LANESCHED_RESET) pend_q <= '0;
    else                     pend_q <= pend_d;
  end
`endif

  assign bus.SC_LANESCHED_PAT_OUT   = pat_q;
  assign bus.SC_LANESCHED_LOAD_OUT  = load_q;
  assign bus.SC_LANESCHED_SHIFT_OUT = shift_q;
  assign bus.SC_LANESCHED_BUSY_OUT  = busy_q;

endmodule
